// File: rtl/gpu_warp_scheduler.sv
// rtl/gpu_warp_scheduler.sv - round-robin scheduler sharing one gpu_warp unit among resident warps
// Optional feature macro WARP_SCHED_STATS_EN adds saturating issue/stall/empty counters.
module gpu_warp_scheduler #(
    parameter int NUM_WARPS = 4,
    parameter int PC_W      = 16,
    parameter int WID_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             launch_valid,
    output logic             launch_ready,
    input  logic [PC_W-1:0]  launch_pc,
    input  logic [PC_W-1:0]  launch_limit,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [WID_W-1:0] issue_warp_id,
    output logic [PC_W-1:0]  issue_pc,
    input  logic             done_valid,
    input  logic [WID_W-1:0] done_warp_id,
    input  logic [PC_W-1:0]  done_pc,
    input  logic             done_exit,
    output logic             retire_valid,
    output logic [WID_W-1:0] retire_warp_id,
    output logic             idle,
    output logic             err
`ifdef WARP_SCHED_STATS_EN
    ,
    output logic [31:0]      stat_issue_cnt,
    output logic [31:0]      stat_stall_cnt,
    output logic [31:0]      stat_empty_cnt
`endif
);

    typedef enum logic [1:0] {S_FREE, S_READY, S_STAGED, S_BUSY} slot_state_t;

    slot_state_t      r_state     [NUM_WARPS];
    slot_state_t      w_state_nxt [NUM_WARPS];
    logic [PC_W-1:0]  r_pc        [NUM_WARPS];
    logic [PC_W-1:0]  r_limit     [NUM_WARPS];
    logic [WID_W-1:0] r_ptr;
    logic             r_issue_valid;
    logic [WID_W-1:0] r_issue_warp_id;
    logic [PC_W-1:0]  r_issue_pc;
    logic             r_retire_valid;
    logic [WID_W-1:0] r_retire_warp_id;
    logic             r_err;

    logic             w_any_free;
    logic             w_all_free;
    logic             w_any_busy;
    logic [WID_W-1:0] w_free_id;
    logic             w_sel_found;
    logic [WID_W-1:0] w_sel_id;
    logic             w_hs;
    logic             w_load_en;
    logic             w_load;
    logic             w_launch_alloc;
    logic             w_done_busy;
    logic             w_done_retire;
    logic [WID_W-1:0] w_ptr_nxt;

    always_comb begin
        w_any_free = 1'b0;
        w_all_free = 1'b1;
        w_any_busy = 1'b0;
        w_free_id  = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (r_state[i] == S_FREE) begin
                w_any_free = 1'b1;
                w_free_id  = WID_W'(i);
            end else begin
                w_all_free = 1'b0;
            end
            if (r_state[i] == S_BUSY) w_any_busy = 1'b1;
        end
    end

    // Walk downwards from the farthest offset so the slot nearest the pointer wins.
    always_comb begin : rr_pick
        int j;
        j           = 0;
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_WARPS) j = j - NUM_WARPS;
            if (r_state[j] == S_READY) begin
                w_sel_found = 1'b1;
                w_sel_id    = WID_W'(j);
            end
        end
    end

    assign launch_ready   = rst_n && w_any_free;
    assign w_launch_alloc = launch_valid && launch_ready && (launch_pc < launch_limit);
    assign w_hs           = r_issue_valid && issue_ready;
    assign w_load_en      = !r_issue_valid || w_hs;
    assign w_load         = w_load_en && w_sel_found;
    assign w_done_busy    = done_valid && (int'(done_warp_id) < NUM_WARPS) &&
                            (r_state[done_warp_id] == S_BUSY);
    assign w_done_retire  = w_done_busy && (done_exit || (done_pc >= r_limit[done_warp_id]));
    assign w_ptr_nxt      = (r_issue_warp_id == WID_W'(NUM_WARPS - 1)) ? '0 : r_issue_warp_id + 1'b1;

    // Each event can only touch a slot in one specific state, so they never collide.
    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++) w_state_nxt[i] = r_state[i];
        if (w_launch_alloc) w_state_nxt[w_free_id] = S_READY;
        if (w_load) w_state_nxt[w_sel_id] = S_STAGED;
        if (w_hs) w_state_nxt[r_issue_warp_id] = S_BUSY;
        if (w_done_busy) w_state_nxt[done_warp_id] = w_done_retire ? S_FREE : S_READY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_state[i] <= S_FREE;
                r_pc[i]    <= '0;
                r_limit[i] <= '0;
            end
            r_ptr            <= '0;
            r_issue_valid    <= 1'b0;
            r_issue_warp_id  <= '0;
            r_issue_pc       <= '0;
            r_retire_valid   <= 1'b0;
            r_retire_warp_id <= '0;
            r_err            <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) r_state[i] <= w_state_nxt[i];
            if (w_launch_alloc) begin
                r_pc[w_free_id]    <= launch_pc;
                r_limit[w_free_id] <= launch_limit;
            end
            if (w_done_busy && !w_done_retire) r_pc[done_warp_id] <= done_pc;
            if (w_hs) r_ptr <= w_ptr_nxt;
            if (w_load_en) begin
                r_issue_valid <= w_sel_found;
                if (w_sel_found) begin
                    r_issue_warp_id <= w_sel_id;
                    r_issue_pc      <= r_pc[w_sel_id];
                end
            end
            r_retire_valid <= w_done_retire;
            if (w_done_retire) r_retire_warp_id <= done_warp_id;
            if (done_valid && !w_done_busy) r_err <= 1'b1;
        end
    end

    assign issue_valid    = r_issue_valid;
    assign issue_warp_id  = r_issue_warp_id;
    assign issue_pc       = r_issue_pc;
    assign retire_valid   = r_retire_valid;
    assign retire_warp_id = r_retire_warp_id;
    assign err            = r_err;
    assign idle           = w_all_free && !r_issue_valid;

`ifdef WARP_SCHED_STATS_EN
    logic [31:0] r_stat_issue;
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issue <= '0;
            r_stat_stall <= '0;
            r_stat_empty <= '0;
        end else begin
            if (w_hs && (r_stat_issue != '1)) r_stat_issue <= r_stat_issue + 32'd1;
            if (r_issue_valid && !issue_ready && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 32'd1;
            if (!r_issue_valid && w_any_busy && (r_stat_empty != '1))
                r_stat_empty <= r_stat_empty + 32'd1;
        end
    end

    assign stat_issue_cnt = r_stat_issue;
    assign stat_stall_cnt = r_stat_stall;
    assign stat_empty_cnt = r_stat_empty;
`endif

endmodule

// File: tb/tb_gpu_warp_scheduler.sv
// tb/tb_gpu_warp_scheduler.sv - directed scoreboard bench for gpu_warp_scheduler
module tb_gpu_warp_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        launch_valid;
    logic        launch_ready;
    logic [15:0] launch_pc;
    logic [15:0] launch_limit;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_warp_id;
    logic [15:0] issue_pc;
    logic        done_valid;
    logic [1:0]  done_warp_id;
    logic [15:0] done_pc;
    logic        done_exit;
    logic        retire_valid;
    logic [1:0]  retire_warp_id;
    logic        idle;
    logic        err;
`ifdef WARP_SCHED_STATS_EN
    logic [31:0] stat_issue_cnt;
    logic [31:0] stat_stall_cnt;
    logic [31:0] stat_empty_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    logic [17:0] exp_issue[$];
    logic [1:0]  exp_retire[$];

    gpu_warp_scheduler #(.NUM_WARPS(4), .PC_W(16), .WID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .launch_valid(launch_valid), .launch_ready(launch_ready),
        .launch_pc(launch_pc), .launch_limit(launch_limit),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_warp_id(issue_warp_id), .issue_pc(issue_pc),
        .done_valid(done_valid), .done_warp_id(done_warp_id),
        .done_pc(done_pc), .done_exit(done_exit),
        .retire_valid(retire_valid), .retire_warp_id(retire_warp_id),
        .idle(idle), .err(err)
`ifdef WARP_SCHED_STATS_EN
        ,
        .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt),
        .stat_empty_cnt(stat_empty_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int target);
        int k;
        k = 0;
        while (hs_cnt < target && k < 50) begin
            tick();
            k++;
        end
        check("hs_wait_timeout", 32'(hs_cnt >= target), 32'd1);
    endtask

    task automatic do_done(input logic [1:0] id, input logic [15:0] pc, input logic ex);
        done_valid   = 1'b1;
        done_warp_id = id;
        done_pc      = pc;
        done_exit    = ex;
        tick();
        done_valid   = 1'b0;
        done_exit    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
            hs_cnt++;
            if (exp_issue.size() == 0) begin
                check("issue_unexpected_id", {30'd0, issue_warp_id}, 32'hFFFF_FFFF);
            end else begin
                logic [17:0] e;
                e = exp_issue.pop_front();
                check("issue_id", {30'd0, issue_warp_id}, {30'd0, e[17:16]});
                check("issue_pc", {16'd0, issue_pc}, {16'd0, e[15:0]});
            end
        end
        if (rst_n === 1'b1 && retire_valid === 1'b1) begin
            if (exp_retire.size() == 0) begin
                check("retire_unexpected_id", {30'd0, retire_warp_id}, 32'hFFFF_FFFF);
            end else begin
                logic [1:0] r;
                r = exp_retire.pop_front();
                check("retire_id", {30'd0, retire_warp_id}, {30'd0, r});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; launch_valid = 1'b0; launch_pc = '0; launch_limit = '0;
        issue_ready = 1'b0; done_valid = 1'b0; done_warp_id = '0; done_pc = '0; done_exit = 1'b0;
        #2 rst_n = 1'b0;
        tick(); tick();
        check("rst_launch_ready", 32'(launch_ready), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_issue_id", 32'(issue_warp_id), 32'd0);
        check("rst_issue_pc", 32'(issue_pc), 32'd0);
        check("rst_retire_valid", 32'(retire_valid), 32'd0);
        check("rst_retire_id", 32'(retire_warp_id), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            tick();
            check("quiet_idle", 32'(idle), 32'd1);
            check("quiet_launch_ready", 32'(launch_ready), 32'd1);
            check("quiet_issue_valid", 32'(issue_valid), 32'd0);
            check("quiet_err", 32'(err), 32'd0);
        end

        // single warp: two issues then retire on limit
        issue_ready  = 1'b1;
        launch_valid = 1'b1; launch_pc = 16'h0010; launch_limit = 16'h0012;
        exp_issue.push_back({2'd0, 16'h0010});
        tick();
        launch_valid = 1'b0;
        check("lat_n1_issue_valid", 32'(issue_valid), 32'd0);
        tick();
        check("lat_n2_issue_valid", 32'(issue_valid), 32'd1);
        wait_hs(1);
        exp_issue.push_back({2'd0, 16'h0011});
        do_done(2'd0, 16'h0011, 1'b0);
        check("turn_n1_issue_valid", 32'(issue_valid), 32'd0);
        tick();
        check("turn_n2_issue_valid", 32'(issue_valid), 32'd1);
        wait_hs(2);
        exp_retire.push_back(2'd0);
        do_done(2'd0, 16'h0012, 1'b0);
        check("single_retire_valid", 32'(retire_valid), 32'd1);
        check("single_retire_id", 32'(retire_warp_id), 32'd0);
        check("single_idle", 32'(idle), 32'd1);
        tick();
        check("single_retire_pulse_end", 32'(retire_valid), 32'd0);

        // four warps fill every slot, then a second round-robin pass
        for (int w = 0; w < 4; w++) begin
            launch_valid = 1'b1; launch_pc = 16'((w + 1) << 8); launch_limit = 16'hFFFF;
            check("fill_launch_ready", 32'(launch_ready), 32'd1);
            exp_issue.push_back({2'(w), 16'((w + 1) << 8)});
            tick();
        end
        launch_pc = 16'h0500;
        check("full_launch_ready", 32'(launch_ready), 32'd0);
        launch_valid = 1'b0;
        wait_hs(6);
        for (int w = 0; w < 4; w++) begin
            exp_issue.push_back({2'(w), 16'(((w + 1) << 8) + 1)});
            do_done(2'(w), 16'(((w + 1) << 8) + 1), 1'b0);
        end
        wait_hs(10);

        // back-pressure holds the staged warp steady
        issue_ready = 1'b0;
        exp_issue.push_back({2'd1, 16'h0202});
        do_done(2'd1, 16'h0202, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("stall_issue_valid", 32'(issue_valid), 32'd1);
            check("stall_issue_id", 32'(issue_warp_id), 32'd1);
            check("stall_issue_pc", 32'(issue_pc), 32'h0202);
            tick();
        end
        check("stall_no_grant", 32'(hs_cnt), 32'd10);
        issue_ready = 1'b1;
        wait_hs(11);

        // retire slot 2, then hit it with a stray done
        exp_retire.push_back(2'd2);
        do_done(2'd2, 16'h0300, 1'b1);
        check("exit_retire_valid", 32'(retire_valid), 32'd1);
        check("exit_retire_id", 32'(retire_warp_id), 32'd2);
        check("pre_err", 32'(err), 32'd0);
        do_done(2'd2, 16'h0999, 1'b0);
        check("err_set", 32'(err), 32'd1);
        check("err_no_retire", 32'(retire_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("err_sticky", 32'(err), 32'd1);
            check("slot2_still_free", 32'(launch_ready), 32'd1);
            check("err_no_issue", 32'(issue_valid), 32'd0);
        end
        exp_issue.push_back({2'd0, 16'h0102});
        do_done(2'd0, 16'h0102, 1'b0);
        wait_hs(12);

        // drain remaining warps: exit, limit, exit
        exp_retire.push_back(2'd0);
        do_done(2'd0, 16'h0103, 1'b1);
        exp_retire.push_back(2'd1);
        do_done(2'd1, 16'hFFFF, 1'b0);
        exp_retire.push_back(2'd3);
        do_done(2'd3, 16'h0402, 1'b1);
        tick();
        check("drain_idle", 32'(idle), 32'd1);
        check("drain_err_sticky", 32'(err), 32'd1);

        // empty-range launch is swallowed
        launch_valid = 1'b1; launch_pc = 16'h0020; launch_limit = 16'h0020;
        check("empty_launch_ready", 32'(launch_ready), 32'd1);
        tick();
        launch_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("empty_idle", 32'(idle), 32'd1);
            check("empty_issue_valid", 32'(issue_valid), 32'd0);
            check("empty_retire_valid", 32'(retire_valid), 32'd0);
            tick();
        end

        check("issue_queue_drained", 32'(exp_issue.size()), 32'd0);
        check("retire_queue_drained", 32'(exp_retire.size()), 32'd0);
        check("total_handshakes", 32'(hs_cnt), 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_warp_scheduler.md
Name: gpu_warp_scheduler

Overview:
- Round-robin scheduler that shares one gpu_warp execution unit among up to NUM_WARPS resident warps.
- Accepts warp launches (start PC plus PC limit) and issues one warp at a time to the execution unit.
- Collects each warp's next PC and exit flag on completion, then re-queues or retires the warp.
- Sits between the top-level gpu block and gpu_warp, replacing the single-warp pc_in/pc_out loop.

Parameters:
- NUM_WARPS, 4, number of warp slots (2..16).
- PC_W, 16, PC and limit width.
- WID_W, 2, warp-id width; must equal clog2(NUM_WARPS).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- launch_valid  in  1  launch request.
- launch_ready  out  1  a FREE slot exists.
- launch_pc  in  PC_W  warp start PC.
- launch_limit  in  PC_W  warp retires when its PC >= this value.
- issue_valid  out  1  warp presented to the execution unit.
- issue_ready  in  1  execution unit accepts the warp.
- issue_warp_id  out  WID_W  id of the presented warp.
- issue_pc  out  PC_W  PC of the presented warp.
- done_valid  in  1  execution unit finished a warp step.
- done_warp_id  in  WID_W  id of the finished warp.
- done_pc  in  PC_W  next PC returned for that warp.
- done_exit  in  1  warp executed an exit.
- retire_valid  out  1  one-cycle pulse: a warp retired.
- retire_warp_id  out  WID_W  id of the retired warp.
- idle  out  1  all slots FREE and issue_valid=0.
- err  out  1  sticky protocol error.

Behaviour:
- Per-slot state FREE -> READY -> STAGED -> BUSY -> (READY | FREE); per-slot pc and limit registers.
- Reset (async, rst_n=0):
  - all slots FREE; round-robin pointer = 0.
  - issue_valid=0, issue_warp_id=0, issue_pc=0.
  - retire_valid=0, retire_warp_id=0, err=0.
  - launch_ready=0 while in reset; idle=1.
- Reset asserted mid-operation discards all in-flight and staged warps without any retire pulses.
- Launch:
  - launch_ready is combinational: 1 iff any slot is FREE, using state registers at the start of the cycle.
  - On launch_valid && launch_ready, the lowest-index FREE slot loads pc and limit and goes READY.
  - If launch_pc >= launch_limit, the launch is accepted and discarded: no slot is allocated, no retire pulse.
  - A slot freed by retirement in cycle N is allocatable from cycle N+1.
- Issue (registered output stage):
  - When the stage is empty, or is handshaking this cycle, it loads the first READY slot at or after the pointer (wrapping modulo NUM_WARPS).
  - The loaded slot goes READY -> STAGED; issue_valid rises the next cycle.
  - The slot being granted this cycle is excluded from the load.
  - issue_warp_id and issue_pc stay stable while issue_valid && !issue_ready.
  - On handshake: the slot goes STAGED -> BUSY and pointer = granted id + 1 (mod NUM_WARPS).
  - Minimum latency: launch accepted in cycle N -> issue_valid in cycle N+2.
  - Back-to-back issue of distinct READY warps sustains one warp per cycle.
- Completion:
  - done_valid with a BUSY slot:
    - if done_exit=1 or done_pc >= limit: slot goes FREE; retire_valid pulses next cycle with that id.
    - otherwise: slot pc = done_pc, slot goes READY, eligible for staging from the next cycle.
  - done_valid for a non-BUSY slot is ignored and sets err=1; err clears only on reset.
- Simultaneous events: launch, issue handshake and done in the same cycle are all legal and all take effect.
- Arithmetic: PC comparisons are unsigned PC_W-bit; no wrap of the PC is performed.
- Single warp: the same warp id may be re-issued after its done, with two-cycle turnaround (done N -> issue_valid N+2).

Optional Feature:
- Macro WARP_SCHED_STATS_EN.
- When defined, adds three outputs, reset to 0, saturating at all-ones:
  - stat_issue_cnt  out  32  counts issue handshakes.
  - stat_stall_cnt  out  32  counts cycles with issue_valid && !issue_ready.
  - stat_empty_cnt  out  32  counts cycles with issue_valid=0 and any slot BUSY.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then release, no stimulus -> idle=1, launch_ready=1, issue_valid=0, err=0 for 20 cycles.
- Launch pc=0x0010, limit=0x0012, issue_ready=1; done returns 0x0011 then 0x0012 -> two issues (pc 0x0010, 0x0011), then retire_valid pulse with id 0, idle=1.
- Launch 4 warps (pc 0x0100/0x0200/0x0300/0x0400, limit 0xFFFF); 5th launch_valid -> launch_ready=0; issue order ids 0,1,2,3; done each with done_pc+1 -> next round order 0,1,2,3.
- Hold issue_ready=0 for 5 cycles with a warp staged -> issue_warp_id/issue_pc constant, slot not granted until issue_ready=1.
- done_valid for a FREE id 2 -> err=1 and stays 1; slot 2 remains FREE; other warps unaffected.
- Launch pc=0x0020, limit=0x0020 -> accepted, no issue, no retire pulse, idle stays 1.
